// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2 with memory-ready wait) then decode/execute of ALU, unary, nop and halt.
// Optional build macro CTRL_MULDIV_EN adds mul/div execute sequences (T3-T6) using the 64-bit Z register.
module control_sequencer #(
   parameter int REG_SEL_W = 4
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 run,
   input  logic [31:0]          ir,
   input  logic                 mem_rdy,
   output logic                 PCout,
   output logic                 Zlowout,
   output logic                 Zhighout,
   output logic                 MDRout,
   output logic                 MARin,
   output logic                 PCin,
   output logic                 MDRin,
   output logic                 IRin,
   output logic                 Yin,
   output logic                 Zlowin,
   output logic                 HIin,
   output logic                 LOin,
   output logic                 IncPC,
   output logic                 Read,
   output logic [4:0]           alu_op,
   output logic                 reg_out,
   output logic                 reg_in,
   output logic [REG_SEL_W-1:0] reg_sel,
   output logic                 busy,
   output logic                 halted,
   output logic                 illegal,
   output logic [3:0]           state
);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T1W  = 4'd3,
      T2   = 4'd4,
      T3   = 4'd5,
      T4   = 4'd6,
      T5   = 4'd7,
      T6   = 4'd8,
      HALT = 4'd15
   } state_t;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_bin, is_un, is_nop, is_halt, is_md;
   logic       unused_ir;

   assign opcode    = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];

   assign is_bin  = (opcode >= 5'd3) && (opcode <= 5'd11);
   assign is_un   = (opcode == 5'd17) || (opcode == 5'd18);
   assign is_nop  = (opcode == 5'd26);
   assign is_halt = (opcode == 5'd27);
`ifdef CTRL_MULDIV_EN
   assign is_md   = (opcode == 5'd15) || (opcode == 5'd16);
`else
   assign is_md   = 1'b0;
`endif

   // Handshake: memory data is valid in the cycle mem_rdy=1 while in T1/T1W;
   // the MDR captures it on that edge and the fetch moves on to T2.
   always_comb begin
      state_t after_s;
      after_s   = run ? T0 : IDLE;
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         IDLE: if (run) state_d = T0;
         T0:   state_d = T1;
         T1:   state_d = mem_rdy ? T2 : T1W;
         T1W:  if (mem_rdy) state_d = T2;
         T2:   state_d = T3;
         T3: begin
            if (is_bin || is_un || is_md) begin
               state_d = T4;
            end else if (is_nop) begin
               state_d = after_s;
            end else begin
               state_d = HALT;
               if (!is_halt) illegal_d = 1'b1;
            end
         end
         T4:   state_d = (is_bin || is_md) ? T5 : after_s;
         T5:   state_d = is_md ? T6 : after_s;
         T6:   state_d = after_s;
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q   <= IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      PCout    = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      MDRout   = 1'b0;
      MARin    = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zlowin   = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      alu_op   = 5'd0;
      reg_out  = 1'b0;
      reg_in   = 1'b0;
      reg_sel  = '0;
      case (state_q)
         T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
         end
         T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         // PC was already loaded in T1; waiting only keeps the MDR tracking memory
         T1W: begin
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         T3: begin
            if (is_bin) begin
               reg_out = 1'b1;
               reg_sel = REG_SEL_W'(rb);
               Yin     = 1'b1;
            end else if (is_un) begin
               reg_out = 1'b1;
               reg_sel = REG_SEL_W'(rb);
               alu_op  = opcode;
               Zlowin  = 1'b1;
            end
`ifdef CTRL_MULDIV_EN
            else if (is_md) begin
               reg_out = 1'b1;
               reg_sel = REG_SEL_W'(ra);
               Yin     = 1'b1;
            end
`endif
         end
         T4: begin
            if (is_bin) begin
               reg_out = 1'b1;
               reg_sel = REG_SEL_W'(rc);
               alu_op  = opcode;
               Zlowin  = 1'b1;
            end else if (is_un) begin
               Zlowout = 1'b1;
               reg_in  = 1'b1;
               reg_sel = REG_SEL_W'(ra);
            end
`ifdef CTRL_MULDIV_EN
            else if (is_md) begin
               // Zlowin loads the full 64-bit Z for mul/div results
               reg_out = 1'b1;
               reg_sel = REG_SEL_W'(rb);
               alu_op  = opcode;
               Zlowin  = 1'b1;
            end
`endif
         end
         T5: begin
            if (is_bin) begin
               Zlowout = 1'b1;
               reg_in  = 1'b1;
               reg_sel = REG_SEL_W'(ra);
            end
`ifdef CTRL_MULDIV_EN
            else if (is_md) begin
               Zlowout = 1'b1;
               LOin    = 1'b1;
            end
`endif
         end
`ifdef CTRL_MULDIV_EN
         T6: begin
            if (is_md) begin
               Zhighout = 1'b1;
               HIin     = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   assign busy    = (state_q != IDLE) && (state_q != HALT);
   assign halted  = (state_q == HALT);
   assign illegal = illegal_q;
   assign state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected output vectors built from instruction class and wait count.
module tb_control_sequencer;

   logic        clock, clear, run, mem_rdy;
   logic [31:0] ir;
   logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zlowin;
   logic        HIin, LOin, IncPC, Read, reg_out, reg_in, busy, halted, illegal;
   logic [4:0]  alu_op;
   logic [3:0]  reg_sel;
   logic [3:0]  state;

   control_sequencer #(.REG_SEL_W(4)) dut (
      .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .Zlowin(Zlowin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
      .alu_op(alu_op), .reg_out(reg_out), .reg_in(reg_in), .reg_sel(reg_sel),
      .busy(busy), .halted(halted), .illegal(illegal), .state(state)
   );

   typedef struct packed {
      logic [3:0] st;
      logic pcout, zlowout, zhighout, mdrout, marin, pcin, mdrin, irin;
      logic yin, zlowin, hiin, loin, incpc, read;
      logic [4:0] alu;
      logic rout, rin;
      logic [3:0] sel;
      logic busy, halted, illegal;
   } obs_t;

`ifdef CTRL_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic [31:0] obs;
   assign obs = {state, PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
                 Yin, Zlowin, HIin, LOin, IncPC, Read, alu_op, reg_out, reg_in,
                 reg_sel, busy, halted, illegal};

   logic [31:0] exp_q[$];
   logic        rdy_q[$];
   logic        run_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        m_ill  = 1'b0;
   logic        m_idle = 1'b1;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic obs_t base(input logic [3:0] st);
      obs_t o;
      o = '0;
      o.st      = st;
      o.busy    = (st >= 4'd1) && (st <= 4'd8);
      o.halted  = (st == 4'd15);
      o.illegal = m_ill;
      return o;
   endfunction

   task automatic push(input obs_t o, input logic r, input logic u);
      exp_q.push_back(o);
      rdy_q.push_back(r);
      run_q.push_back(u);
   endtask

   task automatic check(input logic [31:0] e, input string tag);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   function automatic logic rb1();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected cycle-by-cycle outputs of one instruction, from its class
   task automatic build(input logic [31:0] iw, input int waits, input logic run_last,
                        output logic ends_halted);
      obs_t o;
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      op = iw[31:27]; ra = iw[26:23]; rb = iw[22:19]; rc = iw[18:15];
      ends_halted = 1'b0;
      o = base(4'd1); o.pcout = 1; o.marin = 1; o.incpc = 1; o.zlowin = 1;
      push(o, rb1(), rb1());
      o = base(4'd2); o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1;
      push(o, waits == 0, rb1());
      for (int w = 0; w < waits; w++) begin
         o = base(4'd3); o.read = 1; o.mdrin = 1;
         push(o, w == waits - 1, rb1());
      end
      o = base(4'd4); o.mdrout = 1; o.irin = 1;
      push(o, rb1(), rb1());
      if (op >= 5'd3 && op <= 5'd11) begin
         o = base(4'd5); o.rout = 1; o.sel = rb; o.yin = 1;             push(o, rb1(), rb1());
         o = base(4'd6); o.rout = 1; o.sel = rc; o.alu = op; o.zlowin = 1; push(o, rb1(), rb1());
         o = base(4'd7); o.zlowout = 1; o.rin = 1; o.sel = ra;           push(o, rb1(), run_last);
      end else if (op == 5'd17 || op == 5'd18) begin
         o = base(4'd5); o.rout = 1; o.sel = rb; o.alu = op; o.zlowin = 1; push(o, rb1(), rb1());
         o = base(4'd6); o.zlowout = 1; o.rin = 1; o.sel = ra;           push(o, rb1(), run_last);
      end else if (MD && (op == 5'd15 || op == 5'd16)) begin
         o = base(4'd5); o.rout = 1; o.sel = ra; o.yin = 1;             push(o, rb1(), rb1());
         o = base(4'd6); o.rout = 1; o.sel = rb; o.alu = op; o.zlowin = 1; push(o, rb1(), rb1());
         o = base(4'd7); o.zlowout = 1; o.loin = 1;                      push(o, rb1(), rb1());
         o = base(4'd8); o.zhighout = 1; o.hiin = 1;                     push(o, rb1(), run_last);
      end else if (op == 5'd26) begin
         o = base(4'd5); push(o, rb1(), run_last);
      end else begin
         o = base(4'd5); push(o, rb1(), rb1());
         if (op != 5'd27) m_ill = 1'b1;
         for (int k = 0; k < 3; k++) begin
            o = base(4'd15); push(o, rb1(), 1'b1);
         end
         ends_halted = 1'b1;
      end
   endtask

   task automatic execute(input int limit);
      int n;
      logic [31:0] e;
      logic r, u;
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); r = rdy_q.pop_front(); u = run_q.pop_front();
         check(e, $sformatf("state%0d_n%0d", e[31:28], n));
         if (n < limit) begin
            mem_rdy = r; run = u;
            @(posedge clock); @(negedge clock);
         end else begin
            exp_q.delete(); rdy_q.delete(); run_q.delete();
         end
         n++;
      end
   endtask

   // Clear pulsed between edges; outputs must drop before the next edge
   task automatic clear_pulse();
      #1 clear = 1'b1;
      #1;
      m_ill = 1'b0;
      check(32'h0, "async_clear");
      clear = 1'b0; run = 1'b0;
      @(negedge clock);
      m_idle = 1'b1;
   endtask

   task automatic do_instr(input logic [31:0] iw, input int waits, input logic run_last,
                           input int limit);
      logic h;
      obs_t o;
      ir = iw;
      if (m_idle) begin
         o = base(4'd0); push(o, rb1(), 1'b1);
      end
      build(iw, waits, run_last, h);
      execute(limit);
      if (h || limit < 1000) clear_pulse();
      else m_idle = !run_last;
   endtask

   initial begin
      obs_t o;
      clear = 1'b1; run = 1'b0; mem_rdy = 1'b0; ir = 32'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check(32'h0, "reset_state");
      clear = 1'b0;
      o = base(4'd0); push(o, 1'b1, 1'b0); push(o, 1'b0, 1'b0);
      execute(1000);
      // abort add in T4 (records: IDLE,T0,T1,T2,T3 then T4)
      do_instr(32'h18918000, 0, 1'b0, 5);
      do_instr(32'h18918000, 0, 1'b0, 1000);
      do_instr(32'h88900000, 3, 1'b1, 1000);
      do_instr({5'd26, 27'd0}, 0, 1'b0, 1000);
      do_instr(32'hF8000000, 0, 1'b1, 1000);
      do_instr({5'd27, 27'd0}, 1, 1'b1, 1000);
      do_instr({5'd26, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b0, 1000);
      do_instr({5'd16, 4'd2, 4'd3, 19'd0}, 0, 1'b0, 1000);
      do_instr({5'd15, 4'd5, 4'd9, 19'd0}, 2, 1'b0, 1000);
      for (int i = 0; i < 60; i++) begin
         do_instr($urandom, $urandom_range(0, 3), rb1(), 1000);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the datapath's control strobes cycle by cycle, replacing hand-sequenced stimulus. It runs the fetch sequence T0–T2 with a memory-ready handshake, then decodes the instruction register and runs the execute states for register ALU, unary and halt instructions. It sits beside the datapath. It consumes `ir` and `mem_rdy` and produces every enable, output-select and ALU-operation signal the datapath expects.

## Interface
- `REG_SEL_W`, 4, width of register-select fields (16 GPRs)
- `clock`  in  1  system clock, rising-edge
- `clear`  in  1  reset, asynchronous, active-high
- `run`  in  1  start/continue execution
- `ir`  in  32  datapath IR contents; opcode `ir[31:27]`, Ra `ir[26:23]`, Rb `ir[22:19]`, Rc `ir[18:15]`
- `mem_rdy`  in  1  memory has valid data on Mdatain this cycle
- `PCout, Zlowout, Zhighout, MDRout`  out  1 each  bus-source strobes
- `MARin, PCin, MDRin, IRin, Yin, Zlowin, HIin, LOin`  out  1 each  register load strobes
- `IncPC, Read`  out  1 each  ALU increment-PC / MDR mux select memory
- `alu_op`  out  5  ALU operation (opcode value); 0 when not computing
- `reg_out, reg_in`  out  1 each  GPR drives bus / GPR loads from bus
- `reg_sel`  out  `REG_SEL_W`  GPR index for `reg_out`/`reg_in`
- `busy, halted, illegal`  out  1 each  status
- `state`  out  4  current state (debug)

## Operation
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT. The state register is the only sequential element apart from sticky `illegal`.
- Outputs are a combinational decode of the state register and `ir`. Every strobe is 0 in IDLE and HALT.
- IDLE: `run`=1 → T0.
- T0: PCout, MARin, IncPC, Zlowin → T1.
- T1: Zlowout, PCin, Read, MDRin. `mem_rdy`=1 → T2, otherwise → T1W.
- T1W: Read, MDRin only, so PCin fires exactly once per fetch. Stays in T1W while `mem_rdy`=0, → T2 when `mem_rdy`=1.
- T2: MDRout, IRin → T3.
- Binary ALU, opcodes 00011–01011 (add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: reg_out, sel=Rb, Yin.
  - T4: reg_out, sel=Rc, alu_op=opcode, Zlowin.
  - T5: Zlowout, reg_in, sel=Ra.
- Unary, neg 10001 and not 10010:
  - T3: reg_out, sel=Rb, alu_op=opcode, Zlowin.
  - T4: Zlowout, reg_in, sel=Ra.
- nop 11010: T3 with no strobes.
- halt 11011: T3 → HALT.
- Any other opcode: T3 sets `illegal` (sticky) → HALT.
- Last execute state: `run`=1 → T0, `run`=0 → IDLE.
- HALT is left only by `clear`.
- `busy`=1 in T0–T6. `halted`=1 in HALT.

## Timing
- Reset: `clear` forces IDLE and `illegal`=0 immediately, without waiting for a clock edge. All outputs go to 0 in the same instant. `state`=0000.
- Encoding: IDLE=0, T0=1, T1=2, T1W=3, T2=4, T3=5, T4=6, T5=7, T6=8, HALT=15.
- Each state lasts exactly one clock, except T1W, which lasts as long as `mem_rdy`=0.
- Instruction length with `mem_rdy`=1 in T1: binary 6 cycles, unary 5, nop 4. Each wait cycle adds 1.
- `ir` is sampled only in T3 onward. It must be stable from the edge ending T2 until the last execute state.
- `run` is sampled only in IDLE and in last execute states.
- `clear` mid-instruction aborts it. Strobes are never left asserted.
- `mem_rdy` is ignored outside T1/T1W.

## Configuration
- `CTRL_MULDIV_EN` defined: mul 10000 and div 01111 are legal.
  - T3: reg_out, sel=Ra, Yin.
  - T4: reg_out, sel=Rb, alu_op=opcode, Zlowin, Zhighin-equivalent via Zlowin (64-bit Z).
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Length 7 cycles.
- Not defined: 10000/01111 are illegal. T6 is unreachable. HIin, LOin and Zhighout are tied 0.

## Test plan
- Pulse `clear` mid-T4 of an add → all strobes 0 and `state`=0 before the next edge; `illegal`=0.
- `run`=1, `ir`=0x18918000 (add R1,R2,R3), `mem_rdy`=1 → states 1,2,4,5,6,7. T4 shows sel=3, alu_op=00011. T5 shows reg_in with sel=1.
- neg R1,R2 (`ir`=0x88900000) with `mem_rdy` held low 3 cycles → T1W for 3 cycles with Read=MDRin=1. PCin high for exactly 1 cycle. Total 8 cycles.
- `ir`=0xF8000000 (opcode 11111) → `illegal`=1, `halted`=1. Remains halted with `run`=1 until `clear`.
- halt 11011 → HALT, `illegal`=0. nop with `run`=0 afterwards → IDLE after T3.
- With `CTRL_MULDIV_EN`, mul R2,R3 → LOin in T5, HIin in T6. Without it, same `ir` → `illegal`=1.
